// File: rtl/alu_exec_pipe_if.sv
// Valid/ready bus of the ALU execute pipe: operation request from decode, result toward writeback.
// The master modport is the decode/writeback side; the slave modport is the execute unit.
interface alu_exec_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, ovf, err
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, ovf, err
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage pipelined ALU execute unit: S1 input register, S2 output register, valid/ready flow control.
// Define ALU_SLT_EN to execute signed set-less-than on code 0111; otherwise 0111 takes the error path.
module alu_exec_pipe #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_exec_pipe_if.slave bus
);
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
`ifdef ALU_SLT_EN
    localparam logic [3:0] CTRL_SLT = 4'b0111;
`endif

    logic             s1_valid_r;
    logic [3:0]       s1_ctrl_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             ovf_r;
    logic             err_r;

    logic             s2_load_s;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH+1:0] alu_out_s;

    // Returns {err, ovf, result}; unsupported codes yield a zero result with err set.
    function automatic logic [WIDTH+1:0] alu_eval(input logic [3:0] ctrl,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res_s;
        logic             ovf_s;
        logic             err_s;
        res_s = {WIDTH{1'b0}};
        ovf_s = 1'b0;
        err_s = 1'b0;
        case (ctrl)
            CTRL_AND: res_s = a & b;
            CTRL_OR:  res_s = a | b;
            CTRL_ADD: begin
                res_s = a + b;
                ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (res_s[WIDTH-1] != a[WIDTH-1]);
            end
            CTRL_SUB: begin
                res_s = a - b;
                ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (res_s[WIDTH-1] != a[WIDTH-1]);
            end
`ifdef ALU_SLT_EN
            CTRL_SLT: res_s = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
`endif
            default:  err_s = 1'b1;
        endcase
        return {err_s, ovf_s, res_s};
    endfunction

    // Handshake control: S2 may load when empty or draining, S1 frees when empty or advancing.
    always_comb begin
        s2_load_s  = !out_valid_r || bus.out_ready;
        s1_adv_s   = s1_valid_r && s2_load_s;
        in_ready_s = !reset && (!s1_valid_r || s1_adv_s);
        accept_s   = bus.in_valid && in_ready_s;
        alu_out_s  = alu_eval(s1_ctrl_r, s1_a_r, s1_b_r);
    end

    // S1 input register: an accept reloads it even while its current op advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_ctrl_r  <= 4'b0000;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_ctrl_r  <= bus.alu_ctrl;
            s1_a_r     <= bus.op_a;
            s1_b_r     <= bus.op_b;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2 output register: holds result and flags stable until the consumer takes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r <= alu_out_s[WIDTH-1:0];
                zero_r   <= (alu_out_s[WIDTH-1:0] == {WIDTH{1'b0}});
                ovf_r    <= alu_out_s[WIDTH];
                err_r    <= alu_out_s[WIDTH+1];
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.ovf       = ovf_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_alu_exec_pipe.sv
// Self-checking bench for alu_exec_pipe: directed scenarios plus randomized traffic against a
// wide-arithmetic reference model and an in-order scoreboard.
module tb_alu_exec_pipe;
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [34:0] sb_q[$];

    alu_exec_pipe_if #(.WIDTH(32)) bus ();

    alu_exec_pipe #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reference: {err, ovf, zero, result} from signed 64-bit arithmetic.
    function automatic logic [34:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, wide;
        logic [31:0] r;
        logic ov, er;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        wide = 0;
        r = 32'd0;
        ov = 1'b0;
        er = 1'b0;
        case (c)
            C_AND: r = a & b;
            C_OR:  r = a | b;
            C_ADD: begin
                wide = sa + sb;
                r = wide[31:0];
                ov = (wide > 64'sd2147483647) || (wide < -(64'sd2147483648));
            end
            C_SUB: begin
                wide = sa - sb;
                r = wide[31:0];
                ov = (wide > 64'sd2147483647) || (wide < -(64'sd2147483648));
            end
            C_SLT: begin
`ifdef ALU_SLT_EN
                r = (sa < sb) ? 32'd1 : 32'd0;
`else
                er = 1'b1;
`endif
            end
            default: er = 1'b1;
        endcase
        if (er) r = 32'd0;
        return {er, ov, (r == 32'd0), r};
    endfunction

    // One clock cycle: called at a negedge, drives inputs, samples the pre-edge view, returns at next negedge.
    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, output logic acc, output logic drn, output logic [35:0] obs);
        bus.in_valid  = v;
        bus.alu_ctrl  = c;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        obs = {bus.out_valid, bus.err, bus.ovf, bus.zero, bus.result};
        drn = bus.out_valid && ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one op into an empty pipe, capture S2 one cycle after the accept, then drain it.
    task automatic run_single(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              output logic [35:0] obs, output logic acc);
        logic acc2, drn;
        logic [35:0] o;
        drive(1'b1, c, a, b, 1'b1, acc, drn, o);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, acc2, drn, o);
        obs = {bus.out_valid, bus.err, bus.ovf, bus.zero, bus.result};
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, acc2, drn, o);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.alu_ctrl = 4'd0; bus.op_a = 32'd0; bus.op_b = 32'd0; bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        n_tests++;
        if ({bus.out_valid, bus.err, bus.ovf, bus.zero, bus.result} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b err=%b ovf=%b zero=%b result=%h expected all 0",
                     bus.out_valid, bus.err, bus.ovf, bus.zero, bus.result);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_add_ovf();
        logic [35:0] obs;
        logic acc;
        run_single(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, obs, acc);
        n_tests++;
        if (!acc || obs !== {1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000}) begin
            n_fail++; $display("FAIL add_ovf: got acc=%b obs=%h expected acc=1 obs=%h", acc, obs,
                               {1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000});
        end
    endtask

    task automatic test_sub_and_or();
        logic [35:0] obs;
        logic acc;
        run_single(C_SUB, 32'd5, 32'd5, obs, acc);
        n_tests++;
        if (!acc || obs !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL sub_zero: got acc=%b obs=%h expected result 0 zero 1", acc, obs);
        end
        run_single(C_AND, 32'h0000_F0F0, 32'h0000_0FF0, obs, acc);
        n_tests++;
        if (!acc || obs !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00F0}) begin
            n_fail++; $display("FAIL and_op: got acc=%b obs=%h expected result 000000f0", acc, obs);
        end
        run_single(C_OR, 32'h0000_F0F0, 32'h0000_0FF0, obs, acc);
        n_tests++;
        if (!acc || obs !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_FFF0}) begin
            n_fail++; $display("FAIL or_op: got acc=%b obs=%h expected result 0000fff0", acc, obs);
        end
    endtask

    task automatic test_errors();
        logic [3:0] codes[3];
        logic [35:0] obs;
        logic acc;
        codes[0] = 4'b1110; codes[1] = 4'b1111; codes[2] = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            run_single(codes[i], $urandom, $urandom, obs, acc);
            n_tests++;
            if (!acc || obs !== {1'b1, 1'b1, 1'b0, 1'b1, 32'h0}) begin
                n_fail++; $display("FAIL err_code_%b: got acc=%b obs=%h expected err=1 zero=1 result=0",
                                   codes[i], acc, obs);
            end
        end
    endtask

    task automatic test_slt();
        logic [35:0] obs, exp;
        logic acc;
`ifdef ALU_SLT_EN
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 32'd1};
`else
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 32'd0};
`endif
        run_single(C_SLT, 32'hFFFF_FFFF, 32'd1, obs, acc);
        n_tests++;
        if (!acc || obs !== exp) begin
            n_fail++; $display("FAIL slt: got acc=%b obs=%h expected %h", acc, obs, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] av[4], bv[4];
        logic [34:0] e[4];
        logic acc, drn;
        logic [35:0] o;
        int k, got;
        for (int i = 0; i < 4; i++) begin
            av[i] = $urandom; bv[i] = $urandom; e[i] = ref_op(C_ADD, av[i], bv[i]);
        end
        k = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            drive(k < 4, C_ADD, av[k & 3], bv[k & 3], 1'b0, acc, drn, o);
            if (acc) k++;
        end
        bus.in_valid = 1'b1;
        #1;
        n_tests++;
        if (k != 2 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_fill: got accepts=%0d in_ready=%b expected 2 and 0", k, bus.in_ready);
        end
        n_tests++;
        if ({bus.out_valid, bus.err, bus.ovf, bus.zero, bus.result} !== {1'b1, e[0]}) begin
            n_fail++; $display("FAIL bp_hold: got %h expected %h", {bus.out_valid, bus.err, bus.ovf,
                               bus.zero, bus.result}, {1'b1, e[0]});
        end
        got = 0;
        for (int cyc = 0; cyc < 8 && got < 4; cyc++) begin
            drive(k < 4, C_ADD, av[k & 3], bv[k & 3], 1'b1, acc, drn, o);
            if (acc) k++;
            if (drn) begin
                n_tests++;
                if (o[34:0] !== e[got] || cyc != got) begin
                    n_fail++; $display("FAIL bp_drain_%0d: got %h at cycle %0d expected %h at cycle %0d",
                                       got, o[34:0], cyc, e[got], got);
                end
                got++;
            end
        end
        n_tests++;
        if (got != 4 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_count: got %0d results out_valid=%b expected 4 and 0", got, bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic v, ordy, acc, drn, hold_prev;
        logic [3:0] c;
        logic [31:0] a, b;
        logic [35:0] o, prev_obs;
        logic [34:0] exp;
        logic [31:0] corner[4];
        corner[0] = 32'h0; corner[1] = 32'h7FFF_FFFF; corner[2] = 32'h8000_0000; corner[3] = 32'hFFFF_FFFF;
        sb_q.delete();
        hold_prev = 1'b0;
        prev_obs = 36'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0: c = C_AND;
                1: c = C_OR;
                2, 3: c = C_ADD;
                4, 5: c = C_SUB;
                6: c = C_SLT;
                default: c = 4'($urandom);
            endcase
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            drive(v, c, a, b, ordy, acc, drn, o);
            if (hold_prev) begin
                n_tests++;
                if (o !== prev_obs) begin
                    n_fail++; $display("FAIL rnd_stable cyc %0d: got %h expected %h", cyc, o, prev_obs);
                end
            end
            if (drn) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious cyc %0d: got %h expected no output", cyc, o);
                end else begin
                    exp = sb_q.pop_front();
                    if (o[34:0] !== exp) begin
                        n_fail++; $display("FAIL rnd_result cyc %0d: got %h expected %h", cyc, o[34:0], exp);
                    end
                end
            end
            if (acc) sb_q.push_back(ref_op(c, a, b));
            n_tests++;
            if (sb_q.size() > 2) begin
                n_fail++; $display("FAIL rnd_inflight cyc %0d: got %0d expected at most 2", cyc, sb_q.size());
            end
            hold_prev = o[35] && !ordy;
            prev_obs = o;
        end
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, acc, drn, o);
            if (drn) begin
                exp = sb_q.pop_front();
                n_tests++;
                if (o[34:0] !== exp) begin
                    n_fail++; $display("FAIL rnd_flush: got %h expected %h", o[34:0], exp);
                end
            end
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL rnd_lost: got %0d outstanding expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic acc, drn;
        logic [35:0] o, obs;
        logic [34:0] exp;
        drive(1'b1, C_ADD, $urandom, $urandom, 1'b0, acc, drn, o);
        drive(1'b1, C_SUB, $urandom, $urandom, 1'b0, acc, drn, o);
        reset = 1'b1;
        drive(1'b1, C_ADD, 32'd1, 32'd2, 1'b0, acc, drn, o);
        n_tests++;
        if (acc !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_accept: got %b expected 0", acc);
        end
        n_tests++;
        if ({bus.out_valid, bus.err, bus.ovf, bus.zero, bus.result} !== 36'd0) begin
            n_fail++; $display("FAIL rst_mid_clear: got %h expected 0",
                               {bus.out_valid, bus.err, bus.ovf, bus.zero, bus.result});
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", bus.in_ready);
        end
        exp = ref_op(C_OR, 32'h1234_0000, 32'h0000_5678);
        run_single(C_OR, 32'h1234_0000, 32'h0000_5678, obs, acc);
        n_tests++;
        if (!acc || obs !== {1'b1, exp}) begin
            n_fail++; $display("FAIL rst_mid_next: got acc=%b obs=%h expected %h", acc, obs, {1'b1, exp});
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.alu_ctrl = 4'd0; bus.op_a = 32'd0; bus.op_b = 32'd0; bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_ovf();
        test_sub_and_or();
        test_errors();
        test_slt();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
